// File: rtl/lobster_alu_cache.sv
// lobster128 execution datapath: combinational 128-bit ALU alongside a
// direct-mapped one-word-per-line instruction cache with a registered read port.
module lobster_alu_cache #(
   parameter int unsigned ADDR_WIDTH = 36,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_LINES  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            op,
   input  logic [127:0]          a,
   input  logic [127:0]          b,
   output logic [127:0]          c,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  inv
);

   localparam int unsigned OFF_W = 3;
   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_SAR  = 4'd7,
      OP_MUL  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10,
      OP_MOV  = 4'd11,
      OP_NOT  = 4'd12,
      OP_NEG  = 4'd13,
      OP_MIN  = 4'd14,
      OP_MAX  = 4'd15
   } op_e;

   // ---------------- ALU ----------------
   logic [6:0]   sh;
   logic [127:0] prod;
   logic         lt_s;
   logic         lt_u;

   assign sh   = b[6:0];
   assign prod = a * b;
   assign lt_s = $signed(a) < $signed(b);
   assign lt_u = a < b;

   always_comb begin
      c = '0;
      case (op_e'(op))
         OP_ADD:  c = a + b;
         OP_SUB:  c = a - b;
         OP_AND:  c = a & b;
         OP_OR:   c = a | b;
         OP_XOR:  c = a ^ b;
         OP_SHL:  c = a << sh;
         OP_SHR:  c = a >> sh;
         OP_SAR:  c = 128'($signed(a) >>> sh);
         OP_MUL:  c = prod;
         OP_SLT:  c = 128'(lt_s);
         OP_SLTU: c = 128'(lt_u);
         OP_MOV:  c = b;
         OP_NOT:  c = ~a;
         OP_NEG:  c = 128'(0) - a;
         OP_MIN:  c = lt_s ? a : b;
         OP_MAX:  c = lt_s ? b : a;
         default: c = '0;
      endcase
   end

   // ---------------- cache ----------------
   logic [IDX_W-1:0]      widx;
   logic [IDX_W-1:0]      ridx;
   logic [TAG_W-1:0]      wtag;
   logic [TAG_W-1:0]      rtag;
   logic [NUM_LINES-1:0]  valid;
   logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];
   logic                  hit_c;
   logic [DATA_WIDTH-1:0] rdata_c;
   logic                  unused_offset;

   assign widx = addr_in[OFF_W +: IDX_W];
   assign ridx = addr_out[OFF_W +: IDX_W];
   assign wtag = addr_in[ADDR_WIDTH-1 -: TAG_W];
   assign rtag = addr_out[ADDR_WIDTH-1 -: TAG_W];

   // Byte offset bits are architecturally ignored; accesses are word-aligned.
   assign unused_offset = ^{addr_in[OFF_W-1:0], addr_out[OFF_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[widx] <= 1'b1;
      end
   end

   // Tag/data arrays are not reset; valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         tag_mem[widx]  <= wtag;
         data_mem[widx] <= data_in;
      end
   end

   // Lookup with same-cycle write bypass on index match.
   always_comb begin
      hit_c   = 1'b0;
      rdata_c = '0;
      if (we && (widx == ridx)) begin
         hit_c   = (wtag == rtag);
         rdata_c = data_in;
      end else begin
         hit_c   = valid[ridx] && (tag_mem[ridx] == rtag);
         rdata_c = data_mem[ridx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         inv      <= 1'b1;
      end else begin
         data_out <= hit_c ? rdata_c : '0;
         inv      <= !hit_c;
      end
   end

endmodule

// File: tb/tb_lobster_alu_cache.sv
// Scoreboard bench for lobster_alu_cache: directed ALU vectors and cache
// sequences push expectations; a monitor pops and compares on each result.
module tb_lobster_alu_cache;

   localparam int unsigned AW = 36;
   localparam int unsigned NL = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    op;
   logic [127:0]  a, b, c;
   logic          we;
   logic [AW-1:0] addr_in, addr_out;
   logic [63:0]   data_in, data_out;
   logic          inv;

   logic alu_req = 1'b0;
   logic rd_req  = 1'b0;
   logic rd_pipe = 1'b0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [127:0] c;
      string        name;
   } alu_exp_t;

   typedef struct {
      logic [63:0] d;
      logic        inv;
      string       name;
   } rd_exp_t;

   alu_exp_t alu_q[$];
   rd_exp_t  rd_q[$];

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] MSB  = {1'b1, 127'b0};

   lobster_alu_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .NUM_LINES(NL)) dut (
      .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .c(c),
      .we(we), .addr_in(addr_in), .data_in(data_in),
      .addr_out(addr_out), .data_out(data_out), .inv(inv)
   );

   always #5 clk = ~clk;

   // A read requested in one cycle produces its result after the next edge.
   always @(posedge clk) rd_pipe <= rd_req;

   // Monitor: compare mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (alu_req) begin
         checks++;
         if (alu_q.size() == 0) begin
            failures++;
            $display("FAIL alu_sb_empty: ALU result with no expectation");
         end else begin
            alu_exp_t e;
            e = alu_q.pop_front();
            if (c !== e.c) begin
               failures++;
               $display("FAIL %s: c=%h expected=%h", e.name, c, e.c);
            end
         end
      end
      if (rd_pipe) begin
         checks++;
         if (rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_sb_empty: read result with no expectation");
         end else begin
            rd_exp_t r;
            r = rd_q.pop_front();
            if (data_out !== r.d || inv !== r.inv) begin
               failures++;
               $display("FAIL %s: data_out=%h inv=%b expected data_out=%h inv=%b",
                        r.name, data_out, inv, r.d, r.inv);
            end
         end
      end
   end

   task automatic alu(input logic [3:0] o, input logic [127:0] x, input logic [127:0] y,
                      input logic [127:0] exp_c, input string name);
      alu_exp_t e;
      op = o; a = x; b = y; alu_req = 1'b1;
      e.c = exp_c; e.name = name;
      alu_q.push_back(e);
      @(posedge clk); #1;
      alu_req = 1'b0;
   endtask

   task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                      input logic [63:0] wd, input logic rd, input logic [AW-1:0] ra,
                      input logic [63:0] exp_d, input logic exp_inv, input string name);
      rst = r; we = w; addr_in = wa; data_in = wd;
      rd_req = rd; addr_out = ra;
      if (rd) begin
         rd_exp_t e;
         e.d = exp_d; e.inv = exp_inv; e.name = name;
         rd_q.push_back(e);
      end
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0; rd_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; we = 1'b0; op = '0; a = '0; b = '0;
      addr_in = '0; data_in = '0; addr_out = '0;
      @(posedge clk); #1;

      // Reset state and first post-reset read
      cyc(1, 0, 0, 0, 1, 36'h0, 64'h0, 1'b1, "reset_state");
      cyc(0, 0, 0, 0, 1, 36'h0, 64'h0, 1'b1, "post_reset_miss");

      // ALU vectors
      alu(4'd0,  ONES, 128'd1, 128'd0, "add_wrap");
      alu(4'd1,  128'd0, 128'd1, ONES, "sub_wrap");
      alu(4'd8,  128'd3, 128'd5, 128'd15, "mul_small");
      alu(4'd8,  MSB, 128'd2, 128'd0, "mul_overflow");
      alu(4'd2,  128'hF0F0, 128'hFF00, 128'hF000, "and");
      alu(4'd3,  128'hF0F0, 128'hFF00, 128'hFFF0, "or");
      alu(4'd4,  128'hF0F0, 128'hFF00, 128'h0FF0, "xor");
      alu(4'd7,  MSB, 128'd127, ONES, "sar_msb");
      alu(4'd6,  MSB, 128'd127, 128'd1, "shr_msb");
      alu(4'd5,  128'd1, 128'd4, 128'd16, "shl_4");
      alu(4'd5,  128'h1234, 128'd128, 128'h1234, "shl_b128");
      alu(4'd5,  128'h1234, 128'd129, 128'h2468, "shl_b129");
      alu(4'd9,  ONES, 128'd0, 128'd1, "slt_neg");
      alu(4'd10, ONES, 128'd0, 128'd0, "sltu_big");
      alu(4'd11, 128'd5, 128'd7, 128'd7, "mov");
      alu(4'd12, 128'd0, 128'd0, ONES, "not");
      alu(4'd13, 128'd1, 128'd0, ONES, "neg_one");
      alu(4'd13, 128'd0, 128'd0, 128'd0, "neg_zero");
      alu(4'd14, ONES, 128'd1, ONES, "min_signed");
      alu(4'd15, ONES, 128'd1, 128'd1, "max_signed");

      // Write then read, offset bits ignored
      cyc(0, 1, 36'hF800, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0, 1, 36'hF800, 64'hDEADBEEF_CAFEF00D, 1'b0, "hit_f800");
      cyc(0, 0, 0, 0, 1, 36'hF804, 64'hDEADBEEF_CAFEF00D, 1'b0, "hit_f804_offset");

      // Aliasing at index 0: last write wins
      cyc(0, 1, 36'h0, 64'hAAAA_0000_0000_000A, 0, 0, 0, 0, "");
      cyc(0, 1, 36'(NL * 8), 64'hBBBB_0000_0000_000B, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0, 1, 36'h0, 64'h0, 1'b1, "alias_old_miss");
      cyc(0, 0, 0, 0, 1, 36'(NL * 8), 64'hBBBB_0000_0000_000B, 1'b0, "alias_new_hit");
      cyc(0, 0, 0, 0, 1, 36'hF800, 64'h0, 1'b1, "alias_f800_miss");

      // Write bypass, matching and mismatching tag
      cyc(0, 1, 36'h40, 64'h1234, 1, 36'h40, 64'h1234, 1'b0, "bypass_hit");
      cyc(0, 1, 36'h48, 64'h55, 1, 36'h848, 64'h0, 1'b1, "bypass_tag_miss");
      cyc(0, 0, 0, 0, 1, 36'h48, 64'h55, 1'b0, "after_bypass_hit");

      // Reset mid-stream drops the concurrent write and clears all lines
      cyc(1, 1, 36'h100, 64'h77, 1, 36'h800, 64'h0, 1'b1, "mid_reset_read");
      cyc(0, 0, 0, 0, 1, 36'h100, 64'h0, 1'b1, "reset_write_dropped");
      cyc(0, 0, 0, 0, 1, 36'h800, 64'h0, 1'b1, "reset_clears_800");
      cyc(0, 0, 0, 0, 1, 36'h40, 64'h0, 1'b1, "reset_clears_40");
      cyc(0, 1, 36'h40, 64'h99, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0, 1, 36'h40, 64'h99, 1'b0, "rewrite_hit");

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (alu_q.size() != 0 || rd_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: alu_left=%0d rd_left=%0d expected 0", alu_q.size(), rd_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
